// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding plus command and
// response records sized to the default bus widths.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_NBYTES = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_NBYTES-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared at transfer start, counts stalled cycles,
// flags the last permitted cycle. A limit of 0 removes the timer entirely.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic w_unused;
            assign w_unused = ^{i_clk, i_srst, i_clear, i_enable};
            assign o_tc     = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [CW-1:0] r_count;

            // Saturates at the terminal count; the bridge leaves ACCESS there anyway.
            always_ff @(posedge i_clk) begin
                if (i_srst || i_clear) begin
                    r_count <= '0;
                end else if (i_enable && !o_tc) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_tc = (r_count == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: one command at a time is turned into a SETUP/ACCESS
// transfer, and the result (or a wait-limit abort) is held on the response port.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NBYTES         = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [NBYTES-1:0]     cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [NBYTES-1:0]     PSTRB,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    apb_state_e            r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [NBYTES-1:0]     r_pstrb;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic w_cmd_fire;
    logic w_wait;
    logic w_tc;

    // A new command may enter while the previous response retires this cycle.
    assign cmd_ready  = (r_state == IDLE) && (!r_rsp_valid || rsp_ready);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_wait     = (r_state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk    (PCLK),
        .i_srst   (PRESET),
        .i_clear  (w_cmd_fire),
        .i_enable (w_wait),
        .o_tc     (w_tc)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pstrb     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_paddr   <= cmd_addr;
                        r_pwrite  <= cmd_write;
                        r_pstrb   <= cmd_write ? cmd_strb : '0;
                        r_pwdata  <= cmd_wdata;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing on the same cycle.
                    if (PREADY) begin
                        r_state     <= IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= (r_psel && r_penable && !r_pwrite) ? PRDATA : '0;
                    end else if (w_tc) begin
                        r_state     <= IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign PSELx     = r_psel;
    assign PENABLE   = r_penable;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PSTRB     = r_pstrb;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scenario bench for the APB requester: expected responses are queued when
// commands are issued and compared as the response port delivers them.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [NB-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSELx, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;
    logic [NB-1:0] PSTRB;
    logic [DW-1:0] PWDATA, PRDATA;

    int       checks = 0;
    int       errors = 0;
    apb_rsp_t sb_q[$];
    apb_rsp_t exp_rsp;

    apb_master_bridge #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NBYTES (NB), .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK (PCLK), .PRESET (PRESET),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .PSELx (PSELx), .PENABLE (PENABLE), .PADDR (PADDR), .PWRITE (PWRITE),
        .PSTRB (PSTRB), .PWDATA (PWDATA), .PRDATA (PRDATA), .PREADY (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drive a command until it is accepted; afterwards the DUT is in SETUP.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NB-1:0] s, input logic [DW-1:0] er, input logic ee);
        apb_rsp_t r;
        int n;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
        #1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL issue_wait cmd_ready=%b required 1 within 50 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        r.rdata = er; r.err = ee;
        sb_q.push_back(r);
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick(); tick();
        checks++;
        if ({PSELx, PENABLE, PWRITE} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b required 000", {PSELx, PENABLE, PWRITE});
        end
        checks++;
        if (PADDR !== '0 || PSTRB !== '0 || PWDATA !== '0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%h required 0", PADDR, PSTRB, PWDATA);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h required 0", rsp_valid, rsp_err, rsp_rdata);
        end
        PRESET = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_write_zero_wait();
        PREADY = 1'b1; PRDATA = 32'hCAFEF00D;
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        checks++;
        if ({PSELx, PENABLE, PWRITE, rsp_valid} !== 4'b1010) begin
            errors++; $display("FAIL wr_setup sel/en/wr/rv got %b required 1010", {PSELx, PENABLE, PWRITE, rsp_valid});
        end
        checks++;
        if (PADDR !== 32'h4 || PWDATA !== 32'hDEADBEEF || PSTRB !== 4'hF) begin
            errors++; $display("FAIL wr_setup_bus got %h %h %h required 4 deadbeef f", PADDR, PWDATA, PSTRB);
        end
        tick();
        checks++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b110 || PWDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_access got %b %h required 110 deadbeef", {PSELx, PENABLE, rsp_valid}, PWDATA);
        end
        tick();
        checks++;
        if ({rsp_valid, PSELx, PENABLE} !== 3'b100) begin
            errors++; $display("FAIL wr_done rv/sel/en got %b required 100", {rsp_valid, PSELx, PENABLE});
        end
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL wr_rsp got %h/%b required %h/%b", rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn write addr=04 rdata=%h err=%b", rsp_rdata, rsp_err);
        tick();
    endtask

    task automatic test_read_wait3();
        PREADY = 1'b0; PRDATA = 32'hBAD0BAD0;
        issue(1'b0, 32'h8, 32'h0, 4'hF, 32'h12345678, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            if (t > 1) tick();
            if (t == 5) begin PREADY = 1'b1; PRDATA = 32'h12345678; end
            checks++;
            if (PSTRB !== 4'h0 || rsp_valid !== (t == 6) || PSELx !== (t < 6)) begin
                errors++; $display("FAIL rd_cycle%0d strb=%h rv=%b sel=%b required 0 %b %b", t, PSTRB, rsp_valid, PSELx, t == 6, t < 6);
            end
        end
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL rd_rsp got %h/%b required %h/%b", rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn read addr=08 rdata=%h err=%b", rsp_rdata, rsp_err);
        PRDATA = 32'hBAD0BAD0;
        tick();
    endtask

    task automatic test_timeout();
        PREADY = 1'b0; PRDATA = 32'hFFFF0000;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
        for (int t = 2; t <= 18; t++) begin
            tick();
            if (t == 17) begin
                checks++;
                if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
                    errors++; $display("FAIL to_last_access got %b required 110", {PSELx, PENABLE, rsp_valid});
                end
            end
        end
        checks++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b001) begin
            errors++; $display("FAIL to_abort sel/en/rv got %b required 001", {PSELx, PENABLE, rsp_valid});
        end
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL to_rsp got %h/%b required %h/%b", rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn timeout addr=10 rdata=%h err=%b", rsp_rdata, rsp_err);
        PREADY = 1'b1;
        issue(1'b1, 32'h14, 32'h11223344, 4'hF, 32'h0, 1'b0);
        tick(); tick();
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL to_recover got v=%b %h/%b required 1 %h/%b", rsp_valid, rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn write addr=14 rdata=%h err=%b", rsp_rdata, rsp_err);
        tick();
    endtask

    task automatic test_threshold_ready();
        PREADY = 1'b0; PRDATA = 32'h0;
        issue(1'b0, 32'h18, 32'h0, 4'h0, 32'h13579BDF, 1'b0);
        for (int t = 2; t <= 17; t++) tick();
        PREADY = 1'b1; PRDATA = 32'h13579BDF;
        tick();
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL thr_rsp got v=%b %h/%b required 1 %h/%b", rsp_valid, rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn read addr=18 rdata=%h err=%b", rsp_rdata, rsp_err);
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0; PREADY = 1'b1;
        issue(1'b1, 32'h20, 32'h01020304, 4'hF, 32'h0, 1'b0);
        tick(); tick();
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_strb = 4'hF;
        PRDATA = 32'h5555AAAA;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp.rdata ||
                rsp_err !== exp_rsp.err || PSELx !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d rdy=%b rv=%b %h/%b sel=%b required 0 1 %h/%b 0",
                                   c, cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, exp_rsp.rdata, exp_rsp.err);
            end
            tick();
        end
        $display("txn write addr=20 rdata=%h err=%b", rsp_rdata, rsp_err);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release cmd_ready got %b required 1", cmd_ready);
        end
        sb_q.push_back('{rdata: 32'h5555AAAA, err: 1'b0});
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || PSELx !== 1'b1 || PADDR !== 32'h24 || PWRITE !== 1'b0) begin
            errors++; $display("FAIL bp_accept rv=%b sel=%b addr=%h wr=%b required 0 1 24 0", rsp_valid, PSELx, PADDR, PWRITE);
        end
        tick(); tick();
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL bp_second got v=%b %h/%b required 1 %h/%b", rsp_valid, rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn read addr=24 rdata=%h err=%b", rsp_rdata, rsp_err);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] psel_seen;
        logic [5:0] rv_seen;
        rsp_ready = 1'b1; PREADY = 1'b1; PRDATA = 32'h77778888;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h0F0F0F0F; cmd_strb = 4'hF;
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 1) begin
                cmd_write = 1'b0; cmd_addr = 32'h44;
                sb_q.push_back('{rdata: 32'h77778888, err: 1'b0});
            end
            if (t == 4) cmd_valid = 1'b0;
            psel_seen[t-1] = PSELx;
            rv_seen[t-1]   = rsp_valid;
            if (rsp_valid === 1'b1) begin
                exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
                checks++;
                if (rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
                    errors++; $display("FAIL b2b_rsp t%0d got %h/%b required %h/%b", t, rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
                end
                $display("txn b2b rdata=%h err=%b", rsp_rdata, rsp_err);
            end
        end
        checks++;
        if (psel_seen !== 6'b011011 || rv_seen !== 6'b100100) begin
            errors++; $display("FAIL b2b_pattern sel=%b rv=%b required 011011 100100", psel_seen, rv_seen);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain pending=%0d required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_partial_strobe();
        PREADY = 1'b1;
        issue(1'b1, 32'h50, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        for (int t = 1; t <= 2; t++) begin
            if (t > 1) tick();
            checks++;
            if (PSTRB !== 4'b0101 || PWDATA !== 32'hAABBCCDD || PSELx !== 1'b1) begin
                errors++; $display("FAIL strb_t%0d got %b %h sel=%b required 0101 aabbccdd 1", t, PSTRB, PWDATA, PSELx);
            end
        end
        tick();
        exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : '{rdata: 32'hX, err: 1'bX};
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_err !== exp_rsp.err) begin
            errors++; $display("FAIL strb_rsp got v=%b %h/%b required 1 %h/%b", rsp_valid, rsp_rdata, rsp_err, exp_rsp.rdata, exp_rsp.err);
        end
        $display("txn write addr=50 strb=0101 rdata=%h err=%b", rsp_rdata, rsp_err);
        tick();
    endtask

    task automatic test_reset_mid();
        PREADY = 1'b0; PRDATA = 32'h99999999;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 32'h99999999, 1'b0);
        tick(); tick(); tick();
        PRESET = 1'b1;
        tick();
        checks++;
        if ({PSELx, PENABLE, rsp_valid, rsp_err} !== 4'b0000 || PADDR !== '0 || rsp_rdata !== '0) begin
            errors++; $display("FAIL rst_mid got sel/en/rv/err=%b addr=%h rd=%h required 0", {PSELx, PENABLE, rsp_valid, rsp_err}, PADDR, rsp_rdata);
        end
        PRESET = 1'b0;
        sb_q.delete();
        PREADY = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || PSELx !== 1'b0) begin
                errors++; $display("FAIL rst_after%0d rv=%b sel=%b required 0 0", c, rsp_valid, PSELx);
            end
        end
        $display("txn reset mid-access discarded");
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; rsp_ready = 1'b1; PRDATA = '0; PREADY = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_timeout();
        test_threshold_ready();
        test_backpressure();
        test_back_to_back();
        test_partial_strobe();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
